// File: rtl/waveshaper_multi.sv
// Multi-mode oscillator waveshaper: computes the phase fraction count/fd with a
// restoring sequential divider and maps it to one of five sample shapes.
module waveshaper_multi #(
  parameter int CNT_W = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] fd,
  input  logic [CNT_W-1:0] count,
  input  logic [2:0]       mode,
  input  logic [OUT_W-1:0] duty,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signal,
  output logic [1:0]       dbg_state
);

  // Handshake: a request is accepted on a rising edge where start=1 and busy=0;
  // done pulses for one cycle exactly OUT_W+1 edges later, when busy also drops.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_SHAPE = 2'd2
  } state_t;

  localparam int IW = $clog2(OUT_W) + 1;
  localparam logic [IW-1:0]    LAST_ITER = IW'(OUT_W - 1);
  localparam logic [OUT_W-1:0] MAX_VAL   = {OUT_W{1'b1}};

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_fd;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_mode;
  logic [OUT_W-1:0] r_duty;
  logic [CNT_W:0]   r_rem;
  logic [OUT_W-1:0] r_q;
  logic [IW-1:0]    r_i;
  logic             r_done;
  logic [OUT_W-1:0] r_signal;

  logic [CNT_W:0]   w_t;
  logic             w_ge;
  logic [CNT_W:0]   w_rem_nx;
  logic [OUT_W-1:0] w_saw;
  logic [OUT_W-1:0] w_tri_t;
  logic [OUT_W-1:0] w_tri;
  logic [OUT_W-1:0] w_shape;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_DIV;
      S_DIV:   if (r_i == LAST_ITER) w_next = S_SHAPE;
      S_SHAPE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One restoring step; with R < fd the shifted value always fits in CNT_W+1 bits.
  always_comb begin
    w_t      = r_rem << 1;
    w_ge     = (w_t >= {1'b0, r_fd});
    w_rem_nx = w_ge ? (w_t - {1'b0, r_fd}) : w_t;
  end

  always_comb begin
    w_saw = r_q;
    if (r_fd == '0)            w_saw = '0;
    else if (r_count >= r_fd)  w_saw = MAX_VAL;
    w_tri_t = w_saw[OUT_W-1] ? ~w_saw : w_saw;
    w_tri   = {w_tri_t[OUT_W-2:0], 1'b0};
    w_shape = '0;
    case (r_mode)
      3'b001:  w_shape = ((r_fd != '0) && (r_count > (r_fd >> 1))) ? MAX_VAL : '0;
      3'b010:  w_shape = w_saw;
      3'b011:  w_shape = w_tri;
      3'b100:  w_shape = ((r_fd != '0) && (w_saw < r_duty)) ? MAX_VAL : '0;
      default: w_shape = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fd     <= '0;
      r_count  <= '0;
      r_mode   <= '0;
      r_duty   <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_i      <= '0;
      r_done   <= 1'b0;
      r_signal <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fd    <= fd;
            r_count <= count;
            r_mode  <= mode;
            r_duty  <= duty;
            r_rem   <= {1'b0, count};
            r_q     <= '0;
            r_i     <= '0;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_q   <= {r_q[OUT_W-2:0], w_ge};
          r_i   <= r_i + IW'(1);
        end
        S_SHAPE: begin
          r_signal <= w_shape;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign signal    = r_signal;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_waveshaper_multi.sv
// Bench for waveshaper_multi: directed vector table, control corner sequences,
// and randomized requests scored against an arithmetic reference model.
module tb_waveshaper_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] fd;
  logic [15:0] count;
  logic [2:0]  mode;
  logic [7:0]  duty;
  logic        busy;
  logic        done;
  logic [7:0]  signal;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] fd;
    logic [15:0] count;
    logic [2:0]  mode;
    logic [7:0]  duty;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[$];

  waveshaper_multi #(.CNT_W(16), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .fd(fd), .count(count),
    .mode(mode), .duty(duty), .busy(busy), .done(done), .signal(signal),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: phase fraction by plain integer division, shapes by their rules.
  function automatic logic [7:0] model(input int unsigned f, input int unsigned c,
                                       input int unsigned m, input int unsigned d);
    int unsigned saw, t;
    if (f == 0)       saw = 0;
    else if (c >= f)  saw = 255;
    else              saw = (c * 256) / f;
    case (m)
      1: return (f != 0 && c > f / 2) ? 8'd255 : 8'd0;
      2: return 8'(saw);
      3: begin
        t = (saw >= 128) ? 255 - saw : saw;
        return 8'((t * 2) % 256);
      end
      4: return (f != 0 && saw < d) ? 8'd255 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  // Issues one request from idle, checks latency and done width, returns the sample.
  task automatic run_req(input string name, input logic [15:0] f, input logic [15:0] c,
                         input logic [2:0] m, input logic [7:0] d, output logic [7:0] sig);
    int lat;
    @(negedge clk);
    fd = f; count = c; mode = m; duty = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fd = 16'($urandom); count = 16'($urandom); mode = 3'($urandom); duty = 8'($urandom);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 9);
    sig = signal;
    check({name, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    check({name, "_done_width"}, done, 0);
  endtask

  initial begin
    logic [7:0] got;
    int n_done;
    rst = 1'b1; start = 1'b0; fd = '0; count = '0; mode = '0; duty = '0;
    repeat (3) @(negedge clk);
    check("reset_signal", signal, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;

    vecs.push_back('{16'd12004, 16'd6002,  3'd1, 8'd0,  8'd0});
    vecs.push_back('{16'd12004, 16'd6003,  3'd1, 8'd0,  8'd255});
    vecs.push_back('{16'd12004, 16'd22624, 3'd1, 8'd0,  8'd255});
    vecs.push_back('{16'd200,   16'd0,     3'd2, 8'd0,  8'd0});
    vecs.push_back('{16'd200,   16'd100,   3'd2, 8'd0,  8'd128});
    vecs.push_back('{16'd200,   16'd199,   3'd2, 8'd0,  8'd254});
    vecs.push_back('{16'd200,   16'd250,   3'd2, 8'd0,  8'd255});
    vecs.push_back('{16'd200,   16'd50,    3'd3, 8'd0,  8'd128});
    vecs.push_back('{16'd200,   16'd150,   3'd3, 8'd0,  8'd126});
    vecs.push_back('{16'd200,   16'd0,     3'd3, 8'd0,  8'd0});
    vecs.push_back('{16'd200,   16'd49,    3'd4, 8'd64, 8'd255});
    vecs.push_back('{16'd200,   16'd50,    3'd4, 8'd64, 8'd0});
    vecs.push_back('{16'd200,   16'd0,     3'd4, 8'd0,  8'd0});
    vecs.push_back('{16'd200,   16'd150,   3'd4, 8'd0,  8'd0});
    for (int m = 0; m <= 4; m++)
      vecs.push_back('{16'd0, 16'd77, 3'(m), 8'd200, 8'd0});
    vecs.push_back('{16'd200, 16'd100, 3'd7, 8'd200, 8'd0});
    vecs.push_back('{16'd200, 16'd100, 3'd5, 8'd200, 8'd0});

    for (int k = 0; k < vecs.size(); k++) begin
      run_req($sformatf("vec%0d", k), vecs[k].fd, vecs[k].count, vecs[k].mode,
              vecs[k].duty, got);
      check($sformatf("vec%0d_signal", k), got, vecs[k].exp);
    end

    // Second start and operand changes mid-DIV must not disturb the first request.
    @(negedge clk);
    fd = 16'd200; count = 16'd100; mode = 3'd2; duty = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; count = 16'd199; mode = 3'd3; fd = 16'd7;
    @(negedge clk);
    start = 1'b0;
    n_done = 0; got = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin n_done++; got = signal; end
    end
    check("restart_done_count", n_done, 1);
    check("restart_result", got, 128);

    // Reset on DIV cycle 4 aborts the request.
    run_req("pre_abort", 16'd200, 16'd100, 3'd2, 8'd0, got);
    check("pre_abort_signal", got, 128);
    @(negedge clk);
    fd = 16'd200; count = 16'd150; mode = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", done, 0);
    check("abort_signal", signal, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run_req("post_abort", 16'd200, 16'd150, 3'd2, 8'd0, got);
    check("post_abort_signal", got, 192);

    // Randomized requests against the reference model.
    for (int k = 0; k < 300; k++) begin
      logic [15:0] f, c;
      logic [2:0]  m;
      logic [7:0]  d;
      f = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      c = ($urandom_range(0, 3) == 0 || f == 0) ? 16'($urandom)
                                                : 16'($urandom_range(0, int'(f) - 1));
      m = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      exp_q.push_back(model(f, c, m, d));
      run_req("rand", f, c, m, d, got);
      check($sformatf("rand%0d_signal", k), got, exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/waveshaper_multi.md
# waveshaper_multi

Parametrised multi-mode oscillator waveshaper for the synth voice path. From a phase counter value `count` and period `fd` supplied by the note/divider logic, it produces one `OUT_W`-bit sample per `start` request in one of five shapes: off, square, sawtooth, triangle, variable-duty pulse. The phase fraction is computed by an internal restoring sequential divider, so no external divider instance is required. Output feeds the mixer stage, one request per sample tick.

## Interface
- `CNT_W`, 16: width of `fd` and `count`.
- `OUT_W`, 8: sample width; also the number of divider iterations.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only when `busy`=0.
- `fd`  in  CNT_W  waveform period in clk-divided ticks; 0 means silent.
- `count`  in  CNT_W  current phase position within the period.
- `mode`  in  3  000 off, 001 square, 010 saw, 011 triangle, 100 pulse; 101-111 treated as off.
- `duty`  in  OUT_W  pulse-mode threshold.
- `busy`  out  1  high while a request is in progress.
- `done`  out  1  one-cycle pulse when `signal` is updated.
- `signal`  out  OUT_W  sample; held until the next `done`.

## Operation
- `fd`, `count`, `mode`, and `duty` are latched on the accepting edge. Later input changes do not affect the request in flight.
- States:
  - IDLE: `start`=1 → DIV. Latch inputs, set remainder R=count, set iteration counter i=0.
  - DIV: one iteration per cycle, for OUT_W cycles → SHAPE.
  - SHAPE: 1 cycle. Register `signal`, pulse `done` → IDLE.
- Division is restoring, with R of width CNT_W+1:
  - Each iteration: T=R<<1. If T≥fd, then R=T−fd and shift 1 into q; otherwise R=T and shift 0 into q.
  - After OUT_W iterations, q=floor(count·2^OUT_W/fd).
- The divider always runs for the full OUT_W cycles, including bypass cases. Its result is ignored when fd=0 or count≥fd.
- Phase fraction `saw`:
  - fd=0 → 0.
  - count≥fd → 2^OUT_W−1 (saturate).
  - Otherwise q.
- Shapes (MAX=2^OUT_W−1):
  - off: 0.
  - square: fd=0 → 0. Otherwise MAX if count > (fd>>1), else 0.
  - saw: `saw`.
  - triangle: t = saw[OUT_W−1] ? ~saw : saw. signal = {t[OUT_W−2:0],1'b0}, truncated to OUT_W bits.
  - pulse: fd=0 → 0. Otherwise MAX if saw < duty, else 0. duty=0 gives a constant 0.
- `start` while `busy`=1 is ignored; it is neither queued nor restarted.
- `start` on the same edge that `done` is asserted is ignored, because `busy` is still 1. The earliest new accept is the edge after SHAPE.

## Timing
- Reset values: `signal`=0, `done`=0, `busy`=0, state IDLE, R/q/i cleared.
- Reset mid-operation aborts the request. No `done` pulse follows, and `signal` returns to 0.
- Accept edge E0: `busy`=1 from after E0.
- DIV occupies edges E1..E_OUT_W.
- At edge E_OUT_W+1: `signal` updates, `done`=1 for exactly one cycle, `busy`=0.
- Fixed latency is OUT_W+1 cycles from the accept edge to `done` (9 for OUT_W=8), independent of mode and operands.
- Maximum throughput is one request per OUT_W+2 cycles.

## Test plan
- Square: OUT_W=8, fd=12004, mode=001. count=6002 → `signal`=0; count=6003 → 255; count=22624 → 255. `done` arrives exactly 9 cycles after each accept and is one cycle wide.
- Saw: fd=200, mode=010. count=0 → 0; count=100 → 128; count=199 → 254; count=250 → 255 (saturated).
- Triangle: fd=200, mode=011. count=50 → 128; count=150 → 126; count=0 → 0.
- Pulse: fd=200, mode=100, duty=64. count=49 → 255; count=50 → 0. Also duty=0 → 0 for any count.
- Silent and illegal cases: fd=0 with each mode 000-100 → 0. mode=111 with fd=200, count=100 → 0.
- Control: a second `start` mid-DIV is ignored, with a single `done` and a result from the first operands; changing `count` mid-DIV does not alter the result. Asserting `rst` on DIV cycle 4 gives no `done`, `signal`=0 and `busy`=0 on the next cycle, and a fresh request afterwards completes normally.
